core_op_sched: RTL and testbench

Sequencing and arbitration controller for the shared posit core arithmetic unit (add/sub, mul, div). Two requesters (e.g. two issue lanes) present op + operand FIRs over valid/ready. The block grants one requester round-robin, holds the operands stable on the core for the op's fixed latency, and captures the result. It returns the result with the requester id over a valid/ready response channel. Sits between the decode/FIR-conversion stage and the core arithmetic unit; one operation in flight at a time.

---
 rtl/core_op_sched_pkg.sv | 19 +
 rtl/core_op_sched_if.sv | 35 +++
 rtl/core_op_sched.sv | 174 +++++++++++++++++
 tb/tb_core_op_sched.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_op_sched_pkg.sv
// Shared types for the posit core operation scheduler: op encoding, exponent and FIR operand formats.
package core_op_sched_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_DIV = 3'd3
  } operation_e;

  typedef logic signed [8:0] exponent_t;

  typedef struct packed {
    logic      sign;
    exponent_t te;
    logic [15:0] mant;
  } fir_t;

endpackage

// File: rtl/core_op_sched_if.sv
// Request and response channels of the core operation scheduler.
// master = requesters/consumer side, slave = scheduler side.
interface core_op_sched_if #(
  parameter int FRAC_FULL_SIZE = 32
);
  logic [1:0]                      req_valid_i;
  logic [1:0]                      req_ready_o;
  core_op_sched_pkg::operation_e   req0_op_i;
  core_op_sched_pkg::operation_e   req1_op_i;
  core_op_sched_pkg::fir_t         req0_fir1_i, req0_fir2_i, req0_fir3_i;
  core_op_sched_pkg::fir_t         req1_fir1_i, req1_fir2_i, req1_fir3_i;
  logic                            rsp_valid_o;
  logic                            rsp_ready_i;
  logic                            rsp_id_o;
  logic                            rsp_sign_o;
  core_op_sched_pkg::exponent_t    rsp_te_o;
  logic [FRAC_FULL_SIZE-1:0]       rsp_frac_o;
  logic                            rsp_frac_truncated_o;

  modport master (
    output req_valid_i, req0_op_i, req1_op_i,
           req0_fir1_i, req0_fir2_i, req0_fir3_i,
           req1_fir1_i, req1_fir2_i, req1_fir3_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_sign_o, rsp_te_o,
           rsp_frac_o, rsp_frac_truncated_o
  );

  modport slave (
    input  req_valid_i, req0_op_i, req1_op_i,
           req0_fir1_i, req0_fir2_i, req0_fir3_i,
           req1_fir1_i, req1_fir2_i, req1_fir3_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_id_o, rsp_sign_o, rsp_te_o,
           rsp_frac_o, rsp_frac_truncated_o
  );
endinterface

// File: rtl/core_op_sched.sv
// Round-robin issue/sequencing controller for the shared posit core (one op in flight).
// Optional CORE_OP_SCHED_PERF_EN adds issue and response-stall counters.
module core_op_sched
  import core_op_sched_pkg::*;
#(
  parameter int FRAC_FULL_SIZE = 32,
  parameter int ADD_LAT        = 1,
  parameter int MUL_LAT        = 2,
  parameter int DIV_LAT        = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  core_op_sched_if.slave            bus,
  output operation_e                core_op_o,
  output fir_t                      core_fir1_o,
  output fir_t                      core_fir2_o,
  output fir_t                      core_fir3_o,
  input  logic                      core_sign_i,
  input  exponent_t                 core_te_i,
  input  logic [FRAC_FULL_SIZE-1:0] core_frac_i,
  input  logic                      core_frac_truncated_i,
  output logic                      busy_o
`ifdef CORE_OP_SCHED_PERF_EN
  ,
  output logic [31:0]               perf_issued_o,
  output logic [31:0]               perf_stall_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e state, state_nxt;

  function automatic logic [3:0] lat_of(input operation_e op);
    case (op)
      OP_ADD, OP_SUB: lat_of = 4'(ADD_LAT);
      OP_MUL:         lat_of = 4'(MUL_LAT);
      OP_DIV:         lat_of = 4'(DIV_LAT);
      default:        lat_of = 4'(ADD_LAT);
    endcase
  endfunction

  logic [1:0] grant;
  logic       grant_id;
  logic       accept;
  logic       rr_ptr;
  operation_e op_sel;
  fir_t       fir1_sel, fir2_sel, fir3_sel;

  // Tie goes to the requester that was not granted last.
  always_comb begin
    grant = 2'b00;
    case (bus.req_valid_i)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr_ptr ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  assign grant_id = grant[1];
  assign accept   = (state == S_IDLE) && (grant != 2'b00);
  assign op_sel   = grant_id ? bus.req1_op_i   : bus.req0_op_i;
  assign fir1_sel = grant_id ? bus.req1_fir1_i : bus.req0_fir1_i;
  assign fir2_sel = grant_id ? bus.req1_fir2_i : bus.req0_fir2_i;
  assign fir3_sel = grant_id ? bus.req1_fir3_i : bus.req0_fir3_i;

  // ---- issue stage (p1): operands held on the core until the next accept ----
  operation_e op_p1;
  fir_t       fir1_p1, fir2_p1, fir3_p1;
  logic       id_p1;
  logic [3:0] cnt_p1;

  // ---- capture stage (p2): result held until the response handshake ----
  logic                      rsp_sign_p2;
  exponent_t                 rsp_te_p2;
  logic [FRAC_FULL_SIZE-1:0] rsp_frac_p2;
  logic                      rsp_trunc_p2;
  logic                      vld_p2;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept)            state_nxt = S_WAIT;
      S_WAIT:  if (cnt_p1 == 4'd0)    state_nxt = S_RESP;
      S_RESP:  if (bus.rsp_ready_i)   state_nxt = S_IDLE;
      default:                        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready_o = 2'b00;
    vld_p2          = 1'b0;
    busy_o          = 1'b1;
    case (state)
      S_IDLE: begin
        bus.req_ready_o = grant;
        busy_o          = 1'b0;
      end
      S_RESP:  vld_p2 = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr       <= 1'b1;
      cnt_p1       <= 4'd0;
      op_p1        <= OP_ADD;
      fir1_p1      <= '0;
      fir2_p1      <= '0;
      fir3_p1      <= '0;
      id_p1        <= 1'b0;
      rsp_sign_p2  <= 1'b0;
      rsp_te_p2    <= '0;
      rsp_frac_p2  <= '0;
      rsp_trunc_p2 <= 1'b0;
    end else begin
      if (accept) begin
        op_p1   <= op_sel;
        fir1_p1 <= fir1_sel;
        fir2_p1 <= fir2_sel;
        fir3_p1 <= fir3_sel;
        id_p1   <= grant_id;
        rr_ptr  <= grant_id;
        cnt_p1  <= lat_of(op_sel) - 4'd1;
      end else if (state == S_WAIT && cnt_p1 != 4'd0) begin
        cnt_p1 <= cnt_p1 - 4'd1;
      end
      if (state == S_WAIT && cnt_p1 == 4'd0) begin
        rsp_sign_p2  <= core_sign_i;
        rsp_te_p2    <= core_te_i;
        rsp_frac_p2  <= core_frac_i;
        rsp_trunc_p2 <= core_frac_truncated_i;
      end
    end
  end

  assign core_op_o                = op_p1;
  assign core_fir1_o              = fir1_p1;
  assign core_fir2_o              = fir2_p1;
  assign core_fir3_o              = fir3_p1;
  assign bus.rsp_valid_o          = vld_p2;
  assign bus.rsp_id_o             = id_p1;
  assign bus.rsp_sign_o           = rsp_sign_p2;
  assign bus.rsp_te_o             = rsp_te_p2;
  assign bus.rsp_frac_o           = rsp_frac_p2;
  assign bus.rsp_frac_truncated_o = rsp_trunc_p2;

`ifdef CORE_OP_SCHED_PERF_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_issued_o <= 32'd0;
      perf_stall_o  <= 32'd0;
    end else begin
      if (accept)                             perf_issued_o <= perf_issued_o + 32'd1;
      if (state == S_RESP && !bus.rsp_ready_i) perf_stall_o  <= perf_stall_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_core_op_sched.sv
// Directed bench for core_op_sched; the core model returns a cycle-stamped fraction
// so the capture cycle of every result can be checked exactly.
module tb_core_op_sched;
  import core_op_sched_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  operation_e core_op;
  fir_t       core_fir1, core_fir2, core_fir3;
  logic       core_sign;
  exponent_t  core_te;
  logic [31:0] core_frac;
  logic       core_trunc;
  logic       busy;
`ifdef CORE_OP_SCHED_PERF_EN
  logic [31:0] perf_issued, perf_stall;
`endif

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;

  core_op_sched_if #(.FRAC_FULL_SIZE(32)) bus ();

  core_op_sched #(
    .FRAC_FULL_SIZE(32), .ADD_LAT(1), .MUL_LAT(2), .DIV_LAT(4)
  ) dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .bus                   (bus.slave),
    .core_op_o             (core_op),
    .core_fir1_o           (core_fir1),
    .core_fir2_o           (core_fir2),
    .core_fir3_o           (core_fir3),
    .core_sign_i           (core_sign),
    .core_te_i             (core_te),
    .core_frac_i           (core_frac),
    .core_frac_truncated_i (core_trunc),
    .busy_o                (busy)
`ifdef CORE_OP_SCHED_PERF_EN
    ,
    .perf_issued_o         (perf_issued),
    .perf_stall_o          (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  // Core model: fraction carries the cycle index in which it was presented plus the op.
  always @(posedge clk) begin
    #2;
    ncyc = ncyc + 1;
  end
  assign core_frac  = {ncyc[27:0], 1'b0, core_op};
  assign core_te    = core_fir1.te + core_fir2.te;
  assign core_sign  = core_fir1.sign ^ core_fir2.sign;
  assign core_trunc = ncyc[0];

  function automatic logic [31:0] exp_frac(input int c, input logic [2:0] op);
    return {c[27:0], 1'b0, op};
  endfunction

  localparam fir_t FA = fir_t'{sign: 1'b0, te: 9'sd3,  mant: 16'h1111};
  localparam fir_t FB = fir_t'{sign: 1'b1, te: -9'sd5, mant: 16'h2222};
  localparam fir_t FC = fir_t'{sign: 1'b0, te: 9'sd7,  mant: 16'h3333};

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    total++; if (bus.rsp_valid_o !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid: got %0b want 0", bus.rsp_valid_o); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0b want 0", busy); end
    total++; if (bus.req_ready_o !== 2'b00) begin bad++; $display("FAIL rst_req_ready: got %b want 00", bus.req_ready_o); end
    total++; if (core_op !== OP_ADD) begin bad++; $display("FAIL rst_core_op: got %0d want 0", core_op); end
    total++; if (core_fir1 !== fir_t'(0)) begin bad++; $display("FAIL rst_core_fir1: got %h want 0", core_fir1); end
    total++; if (bus.rsp_frac_o !== 32'd0) begin bad++; $display("FAIL rst_rsp_frac: got %h want 0", bus.rsp_frac_o); end
`ifdef CORE_OP_SCHED_PERF_EN
    total++; if (perf_issued !== 32'd0) begin bad++; $display("FAIL rst_perf_issued: got %0d want 0", perf_issued); end
    total++; if (perf_stall !== 32'd0) begin bad++; $display("FAIL rst_perf_stall: got %0d want 0", perf_stall); end
`endif
  endtask

  task automatic test_add;
    int t, c;
    bus.req0_op_i   = OP_ADD;
    bus.req0_fir1_i = FA;
    bus.req0_fir2_i = FB;
    bus.req0_fir3_i = FC;
    bus.req_valid_i = 2'b01;
    #1;
    total++; if (bus.req_ready_o !== 2'b01) begin bad++; $display("FAIL add_ready: got %b want 01", bus.req_ready_o); end
    t = ncyc;
    tick;
    total++; if (core_op !== OP_ADD) begin bad++; $display("FAIL add_core_op: got %0d want 0", core_op); end
    total++; if (core_fir1 !== FA || core_fir3 !== FC) begin bad++; $display("FAIL add_core_fir: got %h/%h want %h/%h", core_fir1, core_fir3, FA, FC); end
    total++; if (bus.rsp_valid_o !== 1'b0) begin bad++; $display("FAIL add_rsp_early: got %0b want 0", bus.rsp_valid_o); end
    total++; if (busy !== 1'b1 || bus.req_ready_o !== 2'b00) begin bad++; $display("FAIL add_busy_ready: got %0b/%b want 1/00", busy, bus.req_ready_o); end
    bus.req_valid_i = 2'b00;
    tick;
    c = t + 1;
    total++; if (bus.rsp_valid_o !== 1'b1) begin bad++; $display("FAIL add_rsp_valid: got %0b want 1", bus.rsp_valid_o); end
    total++; if (bus.rsp_id_o !== 1'b0) begin bad++; $display("FAIL add_rsp_id: got %0b want 0", bus.rsp_id_o); end
    total++; if (bus.rsp_frac_o !== exp_frac(c, 3'd0)) begin bad++; $display("FAIL add_rsp_frac: got %h want %h", bus.rsp_frac_o, exp_frac(c, 3'd0)); end
    total++; if (bus.rsp_te_o !== exponent_t'(-2)) begin bad++; $display("FAIL add_rsp_te: got %0d want -2", bus.rsp_te_o); end
    total++; if (bus.rsp_sign_o !== 1'b1) begin bad++; $display("FAIL add_rsp_sign: got %0b want 1", bus.rsp_sign_o); end
    total++; if (bus.rsp_frac_truncated_o !== c[0]) begin bad++; $display("FAIL add_rsp_trunc: got %0b want %0b", bus.rsp_frac_truncated_o, c[0]); end
    tick;
    total++; if (bus.rsp_valid_o !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL add_rsp_done: got %0b/%0b want 0/0", bus.rsp_valid_o, busy); end
  endtask

  task automatic test_mul_div;
    int t, t2, rv, ra, rv2;
    logic [31:0] mul_frac;
    rv = -1; ra = -1; rv2 = -1; mul_frac = '0;
    bus.req0_op_i   = OP_MUL;
    bus.req0_fir1_i = FA;
    bus.req0_fir2_i = FB;
    bus.req_valid_i = 2'b01;
    #1;
    t = ncyc;
    tick;
    bus.req0_op_i = OP_DIV;
    for (int i = 0; i < 30; i++) begin
      if (bus.rsp_valid_o && rv < 0) begin rv = ncyc; mul_frac = bus.rsp_frac_o; end
      if (bus.req_ready_o[0]) begin ra = ncyc; break; end
      tick;
    end
    total++; if (rv !== t + 3) begin bad++; $display("FAIL mul_rsp_cycle: got %0d want %0d", rv, t + 3); end
    total++; if (mul_frac !== exp_frac(t + 2, 3'd2)) begin bad++; $display("FAIL mul_rsp_frac: got %h want %h", mul_frac, exp_frac(t + 2, 3'd2)); end
    total++; if (ra !== t + 4) begin bad++; $display("FAIL mul_next_accept: got %0d want %0d", ra, t + 4); end
    t2 = ra;
    tick;
    bus.req_valid_i = 2'b00;
    for (int i = 0; i < 30; i++) begin
      if (bus.rsp_valid_o) begin rv2 = ncyc; break; end
      tick;
    end
    total++; if (rv2 !== t2 + 5) begin bad++; $display("FAIL div_rsp_cycle: got %0d want %0d", rv2, t2 + 5); end
    total++; if (bus.rsp_frac_o !== exp_frac(t2 + 4, 3'd3)) begin bad++; $display("FAIL div_rsp_frac: got %h want %h", bus.rsp_frac_o, exp_frac(t2 + 4, 3'd3)); end
    tick;
  endtask

  task automatic test_round_robin;
    int g[$];
    int r[$];
    int exp_seq[4];
    exp_seq = '{0, 1, 0, 1};
    do_reset;
    bus.req0_op_i   = OP_ADD;
    bus.req1_op_i   = OP_ADD;
    bus.req0_fir1_i = fir_t'{sign: 1'b0, te: 9'sd10, mant: 16'h0};
    bus.req0_fir2_i = fir_t'{sign: 1'b0, te: 9'sd1,  mant: 16'h0};
    bus.req1_fir1_i = fir_t'{sign: 1'b0, te: 9'sd20, mant: 16'h0};
    bus.req1_fir2_i = fir_t'{sign: 1'b0, te: 9'sd2,  mant: 16'h0};
    bus.req_valid_i = 2'b11;
    #1;
    for (int i = 0; i < 60; i++) begin
      if (bus.req_ready_o != 2'b00) g.push_back(int'(bus.req_ready_o[1]));
      if (bus.rsp_valid_o) begin
        r.push_back(int'(bus.rsp_id_o));
        total++;
        if (bus.rsp_te_o !== (bus.rsp_id_o ? exponent_t'(22) : exponent_t'(11))) begin
          bad++; $display("FAIL rr_rsp_te: got %0d for id %0b", bus.rsp_te_o, bus.rsp_id_o);
        end
        if (r.size() == 4) break;
      end
      tick;
    end
    bus.req_valid_i = 2'b00;
    total++; if (g.size() !== 4) begin bad++; $display("FAIL rr_grant_count: got %0d want 4", g.size()); end
    total++; if (r.size() !== 4) begin bad++; $display("FAIL rr_rsp_count: got %0d want 4", r.size()); end
    for (int k = 0; k < 4 && k < g.size(); k++) begin
      total++; if (g[k] !== exp_seq[k]) begin bad++; $display("FAIL rr_grant[%0d]: got %0d want %0d", k, g[k], exp_seq[k]); end
    end
    for (int k = 0; k < 4 && k < r.size(); k++) begin
      total++; if (r[k] !== exp_seq[k]) begin bad++; $display("FAIL rr_rsp_id[%0d]: got %0d want %0d", k, r[k], exp_seq[k]); end
    end
    tick;
  endtask

  task automatic test_stall;
    int t, rc;
    int errs;
    logic [31:0] ef;
    rc = -1; errs = 0;
    bus.rsp_ready_i = 1'b0;
    bus.req0_op_i   = OP_MUL;
    bus.req0_fir1_i = FA;
    bus.req0_fir2_i = FB;
    bus.req_valid_i = 2'b01;
    #1;
    t = ncyc;
    tick;
    bus.req_valid_i = 2'b11;
    for (int i = 0; i < 20; i++) begin
      if (bus.rsp_valid_o) begin rc = ncyc; break; end
      tick;
    end
    total++; if (rc !== t + 3) begin bad++; $display("FAIL stall_rsp_cycle: got %0d want %0d", rc, t + 3); end
    ef = exp_frac(t + 2, 3'd2);
    for (int k = 0; k < 10; k++) begin
      total++;
      if (bus.rsp_valid_o !== 1'b1 || bus.rsp_frac_o !== ef || bus.rsp_te_o !== exponent_t'(-2) ||
          bus.req_ready_o !== 2'b00 || busy !== 1'b1) begin
        bad++;
        $display("FAIL stall_hold[%0d]: got v=%0b frac=%h te=%0d rdy=%b busy=%0b want v=1 frac=%h te=-2 rdy=00 busy=1",
                 k, bus.rsp_valid_o, bus.rsp_frac_o, bus.rsp_te_o, bus.req_ready_o, busy, ef);
      end
      tick;
    end
`ifdef CORE_OP_SCHED_PERF_EN
    total++; if (perf_stall !== 32'd10) begin bad++; $display("FAIL perf_stall: got %0d want 10", perf_stall); end
    total++; if (perf_issued !== 32'd5) begin bad++; $display("FAIL perf_issued: got %0d want 5", perf_issued); end
`endif
    bus.req_valid_i = 2'b00;
    bus.rsp_ready_i = 1'b1;
    tick;
    total++; if (bus.rsp_valid_o !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL stall_release: got %0b/%0b want 0/0", bus.rsp_valid_o, busy); end
  endtask

  task automatic test_reset_mid;
    bus.req0_op_i   = OP_DIV;
    bus.req0_fir1_i = FC;
    bus.req0_fir2_i = FA;
    bus.req_valid_i = 2'b01;
    #1;
    tick;
    bus.req_valid_i = 2'b00;
    tick;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before: got %0b want 1", busy); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    total++; if (bus.rsp_valid_o !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_state: got %0b/%0b want 0/0", bus.rsp_valid_o, busy); end
    total++; if (core_op !== OP_ADD || core_fir1 !== fir_t'(0)) begin bad++; $display("FAIL mid_core_clear: got %0d/%h want 0/0", core_op, core_fir1); end
    total++; if (bus.rsp_frac_o !== 32'd0) begin bad++; $display("FAIL mid_rsp_clear: got %h want 0", bus.rsp_frac_o); end
    bus.req_valid_i = 2'b11;
    #1;
    total++; if (bus.req_ready_o !== 2'b01) begin bad++; $display("FAIL mid_tie_grant: got %b want 01", bus.req_ready_o); end
    bus.req_valid_i = 2'b00;
    tick;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_no_accept: got %0b want 0", busy); end
  endtask

  task automatic test_unlisted;
    int t;
    bus.req1_op_i   = operation_e'(3'd6);
    bus.req1_fir1_i = FA;
    bus.req1_fir2_i = FC;
    bus.req_valid_i = 2'b10;
    #1;
    total++; if (bus.req_ready_o !== 2'b10) begin bad++; $display("FAIL unl_ready: got %b want 10", bus.req_ready_o); end
    t = ncyc;
    tick;
    total++; if (bus.rsp_valid_o !== 1'b0) begin bad++; $display("FAIL unl_rsp_early: got %0b want 0", bus.rsp_valid_o); end
    total++; if (3'(core_op) !== 3'd6) begin bad++; $display("FAIL unl_core_op: got %0d want 6", core_op); end
    bus.req_valid_i = 2'b00;
    tick;
    total++; if (bus.rsp_valid_o !== 1'b1 || bus.rsp_id_o !== 1'b1) begin bad++; $display("FAIL unl_rsp: got v=%0b id=%0b want 1/1", bus.rsp_valid_o, bus.rsp_id_o); end
    total++; if (bus.rsp_frac_o !== exp_frac(t + 1, 3'd6)) begin bad++; $display("FAIL unl_rsp_frac: got %h want %h", bus.rsp_frac_o, exp_frac(t + 1, 3'd6)); end
    total++; if (bus.rsp_te_o !== exponent_t'(10)) begin bad++; $display("FAIL unl_rsp_te: got %0d want 10", bus.rsp_te_o); end
    tick;
    total++; if (bus.rsp_valid_o !== 1'b0) begin bad++; $display("FAIL unl_done: got %0b want 0", bus.rsp_valid_o); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid_i = 2'b00;
    bus.rsp_ready_i = 1'b1;
    bus.req0_op_i   = OP_ADD;
    bus.req1_op_i   = OP_ADD;
    bus.req0_fir1_i = '0; bus.req0_fir2_i = '0; bus.req0_fir3_i = '0;
    bus.req1_fir1_i = '0; bus.req1_fir2_i = '0; bus.req1_fir3_i = '0;
    test_reset;
    test_add;
    test_mul_div;
    test_round_robin;
    test_stall;
    test_reset_mid;
    test_unlisted;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
